// File: rtl/disp_pkg.sv
// Shared display timing constants, framebuffer geometry and address helper
// for the 640x480 scanout path and its framebuffer clients.
package disp_pkg;

   localparam int unsigned HA_END = 639;
   localparam int unsigned LINE   = 799;
   localparam int unsigned VA_END = 479;
   localparam int unsigned SCREEN = 524;

   localparam int unsigned FB_W = 160;
   localparam int unsigned FB_H = 120;
   localparam int unsigned AW   = 15;
   localparam int unsigned DW   = 8;

   typedef logic [AW-1:0] addr_t;
   typedef logic [DW-1:0] pix_t;

   typedef enum logic {
      CL_GAME   = 1'b0,
      CL_RENDER = 1'b1
   } client_e;

   // row*160 + col using shifts only
   function automatic addr_t fb_addr(input addr_t row, input addr_t col);
      return (row << 7) + (row << 5) + col;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer favours the client that
// did not win most recently.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_elig,
   output logic [1:0] o_gnt
);
   import disp_pkg::*;

   client_e    r_ptr;
   logic [1:0] w_gnt;

   always_comb begin
      w_gnt = '0;
      if (i_en) begin
         unique case (i_elig)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = (r_ptr == CL_RENDER) ? 2'b10 : 2'b01;
            default: w_gnt = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_ptr <= CL_GAME;
      else if (|w_gnt)
         r_ptr <= w_gnt[0] ? CL_RENDER : CL_GAME;
   end

   assign o_gnt = w_gnt;

endmodule

// File: rtl/fb_access_arbiter.sv
// Framebuffer RAM scheduler: scanout reads on slots locked to sx/sy, all other
// cycles shared round-robin between game logic (c0) and the renderer (c1).
module fb_access_arbiter #(
   parameter int unsigned FB_W           = disp_pkg::FB_W,
   parameter int unsigned FB_H           = disp_pkg::FB_H,
   parameter int unsigned AW             = disp_pkg::AW,
   parameter int unsigned DW             = disp_pkg::DW,
   parameter int unsigned C1_VBLANK_ONLY = 1
) (
   input  logic            clk_pix,
   input  logic            rst_pix,
   input  logic [9:0]      sx,
   input  logic [9:0]      sy,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic [DW-1:0]   mem_rdata,
   input  logic [1:0]      c_req,
   input  logic [1:0]      c_we,
   input  logic [2*AW-1:0] c_addr,
   input  logic [2*DW-1:0] c_wdata,
   output logic [1:0]      c_gnt,
   output logic [1:0]      c_rvalid,
   output logic [DW-1:0]   c_rdata,
   output logic [DW-1:0]   pix_color,
   output logic            frame_start
);
   import disp_pkg::*;

   localparam logic [AW-1:0] FB_WORDS = AW'(FB_W * FB_H);

   logic          w_slot, w_live, w_wrap;
   logic [9:0]    w_line;
   logic [7:0]    w_col;
   logic [AW-1:0] w_disp_addr;
   logic [1:0]    w_elig, w_gnt;
   logic          w_sel, w_oor, w_c1_ok;
   logic [AW-1:0] w_c_addr;
   logic [DW-1:0] w_c_wdata;

   logic [1:0]    r_rvalid;
   logic          r_rd_oor;
   logic          r_live_d;
   logic [DW-1:0] r_pix;
   logic          r_frame;

   // sx==798 prefetches column 0 of the next line so it is on screen at sx==0
   assign w_wrap = (sx == 10'(LINE - 1));
   assign w_slot = ((sx[1:0] == 2'b10) && (sx <= 10'(HA_END - 5))) || w_wrap;
   assign w_line = !w_wrap ? sy : ((sy == 10'(SCREEN)) ? '0 : sy + 10'd1);
   assign w_col  = w_wrap ? '0 : sx[9:2] + 8'd1;
   assign w_live = w_slot && (w_line <= 10'(VA_END));
   assign w_disp_addr = fb_addr(addr_t'(w_line[9:2]), addr_t'(w_col));

   assign w_c1_ok = (C1_VBLANK_ONLY == 0) || (sy > 10'(VA_END));
   assign w_elig  = {c_req[1] & w_c1_ok, c_req[0]};

   rr_arb2 u_arb (
      .i_clk  (clk_pix),
      .i_rst  (rst_pix),
      .i_en   (!w_live && !rst_pix),
      .i_elig (w_elig),
      .o_gnt  (w_gnt)
   );

   assign w_sel     = w_gnt[1];
   assign w_c_addr  = w_sel ? c_addr[2*AW-1:AW]  : c_addr[AW-1:0];
   assign w_c_wdata = w_sel ? c_wdata[2*DW-1:DW] : c_wdata[DW-1:0];
   assign w_oor     = (w_c_addr >= FB_WORDS);

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!rst_pix) begin
         if (w_live) begin
            mem_en   = 1'b1;
            mem_addr = w_disp_addr;
         end else if ((|w_gnt) && !w_oor) begin
            mem_en    = 1'b1;
            mem_we    = c_we[w_sel];
            mem_addr  = w_c_addr;
            mem_wdata = w_c_wdata;
         end
      end
   end

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         r_rvalid <= '0;
         r_rd_oor <= 1'b0;
         r_live_d <= 1'b0;
         r_pix    <= '0;
         r_frame  <= 1'b0;
      end else begin
         r_rvalid <= w_gnt & ~c_we;
         r_rd_oor <= w_oor;
         r_live_d <= w_live;
         if (sx[1:0] == 2'b11)
            r_pix <= r_live_d ? mem_rdata : '0;
         r_frame  <= (sx == '0) && (sy == '0);
      end
   end

   // Registered outputs are forced low while reset is held so a pending read is dropped
   assign c_gnt       = w_gnt;
   assign c_rvalid    = rst_pix ? '0 : r_rvalid;
   assign c_rdata     = (!rst_pix && (|r_rvalid) && !r_rd_oor) ? mem_rdata : '0;
   assign pix_color   = rst_pix ? '0 : r_pix;
   assign frame_start = !rst_pix && r_frame;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Randomized bench for fb_access_arbiter against a screen-level reference
// model (pixel = framebuffer[(sy/4)*160 + sx/4], round-robin by last winner).
module tb_fb_access_arbiter;
   import disp_pkg::*;

   localparam int NWORDS = 19200;

   logic        clk_pix = 1'b0;
   logic        rst_pix;
   logic [9:0]  sx, sy;
   logic        mem_en, mem_we;
   logic [14:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;
   logic [1:0]  c_req, c_we, c_gnt, c_rvalid;
   logic [29:0] c_addr;
   logic [15:0] c_wdata;
   logic [7:0]  c_rdata, pix_color;
   logic        frame_start;

   always #5 clk_pix = ~clk_pix;

   fb_access_arbiter #(.FB_W(160), .FB_H(120), .AW(15), .DW(8), .C1_VBLANK_ONLY(1)) dut (
      .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
      .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .pix_color(pix_color), .frame_start(frame_start)
   );

   logic [7:0] ram    [NWORDS];
   logic [7:0] ref_fb [NWORDS];

   always @(posedge clk_pix) begin
      if (mem_en && int'(mem_addr) < NWORDS) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (sx=%0d sy=%0d t=%0t)",
                  tag, got, exp, sx, sy, $time);
      end
   endtask

   // client stimulus
   bit          req   [2];
   bit          we    [2];
   int          caddr [2];
   int          cwd   [2];

   // reference model state
   int          last_win   = 1;   // pointer favours c0 after reset
   bit [1:0]    exp_rv     = '0;
   int          exp_rdata  = 0;
   bit          prev_orig  = 0;
   int          contig     = 0;
   bit [1:0]    model_gnt  = '0;
   bit          c0rd_prev  = 0;
   bit          reset_armed = 0;
   bit          just_reset = 0;

   always_comb begin
      c_req   = {req[1], req[0]};
      c_we    = {we[1], we[0]};
      c_addr  = {15'(caddr[1]), 15'(caddr[0])};
      c_wdata = {8'(cwd[1]), 8'(cwd[0])};
   end

   task automatic new_requests();
      for (int i = 0; i < 2; i++) begin
         if (model_gnt[i]) req[i] = 0;
         if (!req[i] && (just_reset || $urandom_range(0, 3) == 0)) begin
            req[i]   = 1;
            we[i]    = (sy > 480 && sy <= 520) ? 1'($urandom_range(0, 1)) : 1'b0;
            caddr[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(19200, 32767))
                                                   : int'($urandom_range(0, 19199));
            cwd[i]   = int'($urandom_range(0, 255));
         end
      end
      just_reset = 0;
   endtask

   task automatic check_cycle(input bit cont);
      int  isx, isy, L, col, win, daddr, wa, epix;
      bit  slot, live, e0, e1, oor;
      bit  [1:0] egnt;
      int  een, ewe, eaddr, ewd;
      isx = int'(sx); isy = int'(sy);
      slot = 0; live = 0; L = 0; col = 0; win = -1; oor = 0;
      egnt = '0; een = 0; ewe = 0; eaddr = 0; ewd = 0; daddr = 0; wa = 0;

      if (rst_pix) begin
         check("rst_gnt",    c_gnt, 0);
         check("rst_en",     mem_en, 0);
         check("rst_rvalid", c_rvalid, 0);
         check("rst_rdata",  c_rdata, 0);
         check("rst_pix",    pix_color, 0);
         check("rst_fs",     frame_start, 0);
         exp_rv = '0; last_win = 1; prev_orig = 0; contig = 0;
         model_gnt = '0; c0rd_prev = 0; just_reset = 1;
         return;
      end

      if (isx <= 634 && isx % 4 == 2) begin
         slot = 1; L = isy; col = isx / 4 + 1;
      end else if (isx == 798) begin
         slot = 1; L = (isy + 1) % 525; col = 0;
      end
      live  = slot && (L < 480);
      daddr = (L / 4) * 160 + col;

      e0 = req[0];
      e1 = req[1] && (isy >= 480);
      if (!live) begin
         if (e0 && e1)  win = 1 - last_win;
         else if (e0)   win = 0;
         else if (e1)   win = 1;
      end

      if (live) begin
         een = 1; eaddr = daddr;
      end else if (win >= 0) begin
         egnt[win] = 1'b1;
         wa  = caddr[win];
         oor = (wa >= NWORDS);
         if (!oor) begin
            een = 1; ewe = int'(we[win]); eaddr = wa; ewd = cwd[win];
         end
      end

      check("c_gnt",  c_gnt, egnt);
      check("mem_en", mem_en, een);
      if (!oor) begin
         check("mem_we",    mem_we, ewe);
         check("mem_addr",  mem_addr, eaddr);
         check("mem_wdata", mem_wdata, ewd);
      end
      check("c_rvalid", c_rvalid, exp_rv);
      if (exp_rv != 0) check("c_rdata", c_rdata, exp_rdata);
      check("frame_start", frame_start, prev_orig);

      contig = cont ? contig + 1 : 1;
      if (contig >= 6) begin
         epix = (isx < 640 && isy < 480) ? int'(ref_fb[(isy / 4) * 160 + isx / 4]) : 0;
         check("pix_color", pix_color, epix);
      end

      // advance model to the next cycle
      model_gnt = egnt;
      exp_rv    = '0;
      c0rd_prev = 0;
      if (win >= 0) begin
         last_win = win;
         if (we[win]) begin
            if (!oor) ref_fb[wa] = 8'(cwd[win]);
         end else begin
            exp_rv[win] = 1'b1;
            exp_rdata   = oor ? 0 : int'(ref_fb[wa]);
            c0rd_prev   = (win == 0);
         end
      end
      prev_orig = (isx == 0 && isy == 0);
   endtask

   task automatic tick(input int nsx, input int nsy, input bit nrst, input bit cont);
      @(posedge clk_pix); #1;
      sx = 10'(nsx); sy = 10'(nsy); rst_pix = nrst;
      new_requests();
      #3;
      check_cycle(cont);
   endtask

   task automatic run_seg(input int sy0, input int sx0, input int ncyc, input bit arm_rst);
      int x, y;
      bit r;
      x = sx0; y = sy0;
      reset_armed = arm_rst;
      for (int n = 0; n < ncyc; n++) begin
         r = reset_armed && c0rd_prev;
         if (r) reset_armed = 0;
         tick(x, y, r, n != 0);
         if (x == 799) begin
            x = 0;
            y = (y == 524) ? 0 : y + 1;
         end else begin
            x++;
         end
      end
      if (reset_armed) check("reset_trigger_reached", 0, 1);
   endtask

   initial begin
      for (int n = 0; n < NWORDS; n++) begin
         ram[n]    = 8'(n);
         ref_fb[n] = 8'(n);
      end
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; we[i] = 0; caddr[i] = 0; cwd[i] = 0;
      end
      sx = '0; sy = '0; rst_pix = 1'b1;

      for (int n = 0; n < 3; n++) tick(0, 0, 1'b1, 1'b0);

      run_seg(7,   780, 2500, 1'b0);   // rows 1-2, pixel 0x40 at sy=8
      run_seg(478, 780, 3300, 1'b0);   // end of active area, c1 released at 480
      run_seg(499, 780, 2500, 1'b1);   // vblank contention plus mid-access reset
      run_seg(523, 700, 2600, 1'b0);   // frame wrap, frame_start
      for (int k = 0; k < 6; k++)
         run_seg(int'($urandom_range(0, 524)), 780, 900, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
Schedules the single-port framebuffer RAM for the 640x480@60 display path. Scanout reads from a 160x120, 8-bit-per-pixel framebuffer, where each stored pixel is scaled 4x4 on screen; these reads take fixed-priority slots locked to the sx/sy counters of the timing generator. All remaining cycles are shared round-robin between two game-side clients: client 0 is game logic, client 1 is the sprite/background renderer. The block sits between the timing generator, the framebuffer RAM and the pixel output stage, all on the pixel clock.

Parameters:
FB_W, 160, framebuffer width in stored pixels
FB_H, 120, framebuffer height in stored pixels
AW, 15, address width; FB_W*FB_H = 19200 words
DW, 8, pixel/data width
C1_VBLANK_ONLY, 1, when 1, client 1 is eligible only while sy > 479

Ports:
clk_pix  in  1  pixel clock
rst_pix  in  1  synchronous active-high reset
sx  in  10  horizontal position from timing generator (0..799)
sy  in  10  vertical position from timing generator (0..524)
mem_en  out  1  RAM access strobe (combinational this cycle)
mem_we  out  1  RAM write enable
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM read data, valid 1 cycle after a read with mem_en high
c_req  in  2  per-client request; held high until granted
c_we  in  2  per-client write (1) / read (0)
c_addr  in  2*AW  client addresses, packed {c1, c0}
c_wdata  in  2*DW  client write data, packed {c1, c0}
c_gnt  out  2  one-hot, one-cycle grant; address and data are sampled this cycle
c_rvalid  out  2  one-hot read-data valid, 1 cycle after a read grant
c_rdata  out  DW  shared read data
pix_color  out  DW  pixel colour aligned with the current sx/sy
frame_start  out  1  one-cycle pulse the cycle after sx==0 && sy==0

Behaviour:
- Reset: all outputs 0; round-robin pointer = client 0; pending-read pipeline and pix_color cleared. Reset in the middle of an access cancels the outstanding c_rvalid.
- Display slot: occurs when (sx[1:0]==2'b10 && sx<=634) or sx==798.
  - Target line: L = sy when sx<=634; when sx==798, L = (sy==524) ? 0 : sy+1.
  - Target column: col = (sx>>2)+1 when sx<=634; col = 0 when sx==798.
  - row = L>>2.
  - The slot is live only if L<=479. A live slot drives mem_en=1, mem_we=0, mem_addr = row*160 + col, computed as (row<<7)+(row<<5)+col at AW bits.
- pix_color capture: occurs on every cycle with sx[1:0]==2'b11, including sx==799.
  - If the previous cycle was a live display slot, pix_color <= mem_rdata; otherwise pix_color <= 0.
  - Net latency is slot + 2 cycles. pix_color holds each stored pixel for exactly sx = 4k..4k+3, with column 0 present at sx==0.
  - pix_color is 0 for sx 640..799 and for sy >= 480.
- Client arbitration: runs only in cycles that are not a live display slot. The display slot has absolute priority.
  - Eligible = c_req[i]. Client 1 is additionally gated by (sy>479) when C1_VBLANK_ONLY=1.
  - When both clients are eligible, grant the client the pointer selects. The pointer then moves to the other client.
  - When one client is eligible, grant it; the pointer moves to the other client.
  - A granted access drives mem_en=1, mem_we=c_we[i], and the client's mem_addr/mem_wdata in the same cycle.
- Read return: the cycle after a client read grant, c_rvalid[i]=1 and c_rdata=mem_rdata. Writes produce no rvalid.
- Out-of-range client address (>=19200): the client is still granted, but mem_en is held 0. If it is a read, c_rvalid is asserted next cycle with c_rdata=0.
- Idle: mem_en=0; mem_addr, mem_wdata and mem_we = 0.
- A request that arrives during a display slot waits and is granted in the next free cycle. At most one client is granted per cycle.
- frame_start is registered from (sx==0 && sy==0).

Decomposition:
- Package disp_pkg holds:
  - timing constants: HA_END=639, LINE=799, VA_END=479, SCREEN=524
  - FB_W, FB_H, AW, DW
  - typedef addr_t (logic [AW-1:0])
  - typedef pix_t (logic [DW-1:0])
  - the function fb_addr(row, col)
- One sub-module, rr_arb2: a two-requester round-robin arbiter with an eligibility mask input, a one-hot grant output and pointer state.
- Display-slot decode and the capture pipeline stay in the top level.

Test Plan:
1. Framebuffer preloaded with word n = n[7:0]; run one frame with no client requests:
   - sy=8, sx=0..3 shows pix_color=0x40 (row 2, col 0 = address 320).
   - sx=636..639 shows 0x9F (col 159); sx=640 shows 0.
   - sy=480 shows 0 throughout.
2. Both clients hold read requests during vblank (sy=500):
   - Grants alternate c0, c1, c0, ...
   - Each c_rvalid lands one cycle after its grant with the correct data.
3. c0 requests a write at sx=2, sy=0:
   - No grant at sx=2 (display address 1 is read instead).
   - c_gnt[0] at sx=3; mem_we=1 with c0's addr and data.
4. C1_VBLANK_ONLY=1 and c1 requests at sy=100:
   - No grant until sy=480, sx=0, where c_gnt[1] fires.
5. c0 reads addr 19200:
   - c_gnt[0]=1 with mem_en=0.
   - Next cycle c_rvalid[0]=1 and c_rdata=0.
6. Assert rst_pix in the cycle after a c0 read grant:
   - No c_rvalid; all outputs 0.
   - Round-robin pointer back at c0.
